// File: rtl/tester_pkg.sv
// ============================================================================
// Module      : tester_pkg
// Description : Shared types and helpers for the exhaustive stimulus tester.
//               Holds the FSM state type, the supported input-count ceiling
//               and the settle-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tester_pkg;

    // Largest DUT input count the tester is sized for
    localparam int MAX_N_IN = 8;

    // Run-sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Settle counter must hold values 0..SETTLE; never narrower than one bit
    function automatic int settle_cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage : tester_pkg

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// Module      : settle_timer
// Description : Clearable up-counter that flags the SETTLE-th enabled cycle.
//               expired is combinational so the owning FSM can leave its
//               wait state on exactly that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer
    import tester_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = settle_cnt_width(SETTLE);
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(SETTLE);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count enabled cycles and park at SETTLE
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != MAX_CNT)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High during the SETTLE-th enabled cycle since the last clear
    assign expired = en && (count_q == LAST_CNT);

endmodule : settle_timer

`default_nettype wire

// File: rtl/exhaustive_tester.sv
// ============================================================================
// Module      : exhaustive_tester
// Description : Walks an N_IN-input combinational DUT through every input
//               value in ascending order, holds each for SETTLE+1 cycles,
//               compares the DUT output with TRUTH_TABLE and reports
//               pass/fail, mismatch count and first failing vector.
//               Optional build macro EXHAUSTIVE_TESTER_STOP_ON_FAIL_EN ends
//               the run at the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exhaustive_tester
    import tester_pkg::*;
#(
    parameter int                      N_IN        = 4,
    parameter int                      SETTLE      = 2,
    parameter logic [(1 << N_IN)-1:0]  TRUTH_TABLE = 16'h8000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_seen
);

    localparam int              ERR_W    = N_IN + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(1 << N_IN);
    localparam logic [N_IN-1:0] ALL_ONES = {N_IN{1'b1}};

    state_t          state_q,      state_d;
    logic [N_IN-1:0] stim_q,       stim_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;
    logic            fail_seen_q,  fail_seen_d;
    logic            busy_q,       busy_d;
    logic            done_q,       done_d;

    logic            timer_clear;
    logic            timer_en;
    logic            timer_expired;
    logic            mismatch;
    logic            last_vector;

    // Settle timing for the vector currently on stim
    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign timer_en    = (state_q == DRIVE);
    assign mismatch    = (dut_out != TRUTH_TABLE[stim_q]);
    assign last_vector = (stim_q == ALL_ONES);

    // Next-state, stimulus and checker update
    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        busy_d       = busy_q;
        done_d       = done_q;
        timer_clear  = 1'b0;

        case (state_q)
            // A new run can be launched from rest or from a finished run
            IDLE, DONE: begin
                if (start) begin
                    state_d      = DRIVE;
                    stim_d       = '0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    timer_clear  = 1'b1;
                end
            end

            DRIVE: begin
                if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                if (mismatch) begin
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    if (!fail_seen_q) begin
                        first_fail_d = stim_q;
                        fail_seen_d  = 1'b1;
                    end
                end
`ifdef EXHAUSTIVE_TESTER_STOP_ON_FAIL_EN
                if (last_vector || mismatch) begin
`else
                if (last_vector) begin
`endif
                    // Finish with stim left on the final (or failing) vector
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d     = DRIVE;
                    stim_d      = stim_q + N_IN'(1);
                    timer_clear = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            stim_q       <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;
    assign fail_seen  = fail_seen_q;
    assign pass       = done_q && (err_count_q == '0);

endmodule : exhaustive_tester

`default_nettype wire

// File: tb/tb_exhaustive_tester.sv
// ============================================================================
// Module      : tb_exhaustive_tester
// Description : Self-checking bench for exhaustive_tester. Two instances
//               (4-input AND reference, 2-input XOR reference) test
//               table-driven stand-in DUTs; expected results come from a
//               vector-level model of a full run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exhaustive_tester;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 4-input instance
    logic        start4 = 1'b0;
    logic        dut_out4;
    logic [3:0]  stim4;
    logic        busy4, done4, pass4, fs4;
    logic [4:0]  err4;
    logic [3:0]  ff4;
    logic [15:0] dut_tt4 = 16'h8000;

    // 2-input instance
    logic        start2 = 1'b0;
    logic        dut_out2;
    logic [1:0]  stim2;
    logic        busy2, done2, pass2, fs2;
    logic [2:0]  err2;
    logic [1:0]  ff2;
    logic [3:0]  dut_tt2 = 4'b0110;

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    always #5 clk = ~clk;

    // Stand-in combinational DUTs described by their own truth tables
    assign dut_out4 = dut_tt4[stim4];
    assign dut_out2 = dut_tt2[stim2];

    exhaustive_tester #(
        .N_IN (4), .SETTLE (2), .TRUTH_TABLE (16'h8000)
    ) u_dut4 (
        .clk (clk), .rst (rst), .start (start4), .dut_out (dut_out4),
        .stim (stim4), .busy (busy4), .done (done4), .pass (pass4),
        .err_count (err4), .first_fail (ff4), .fail_seen (fs4)
    );

    exhaustive_tester #(
        .N_IN (2), .SETTLE (1), .TRUTH_TABLE (4'b0110)
    ) u_dut2 (
        .clk (clk), .rst (rst), .start (start2), .dut_out (dut_out2),
        .stim (stim2), .busy (busy2), .done (done2), .pass (pass2),
        .err_count (err2), .first_fail (ff2), .fail_seen (fs2)
    );

    // Views of whichever instance is under test
    wire       v_busy = sel ? busy2 : busy4;
    wire       v_done = sel ? done2 : done4;
    wire       v_pass = sel ? pass2 : pass4;
    wire       v_fs   = sel ? fs2   : fs4;
    wire [7:0] v_stim = sel ? {6'd0, stim2} : {4'd0, stim4};
    wire [7:0] v_err  = sel ? {5'd0, err2}  : {3'd0, err4};
    wire [7:0] v_ff   = sel ? {6'd0, ff2}   : {4'd0, ff4};

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Whole-run prediction: scan vectors 0..2^n-1 in order
    task automatic predict(input logic [15:0] dut_tt, input logic [15:0] ref_tt,
                           input int n, input int settle,
                           output int errs, output int ff, output int fstim,
                           output int cycles);
        bit stop_on_fail = 1'b0;
        bit found = 1'b0;
        int nvec  = 1 << n;
`ifdef EXHAUSTIVE_TESTER_STOP_ON_FAIL_EN
        stop_on_fail = 1'b1;
`endif
        errs  = 0;
        ff    = 0;
        fstim = nvec - 1;
        for (int k = 0; k < (1 << n); k++) begin
            if (dut_tt[k] != ref_tt[k]) begin
                errs++;
                if (!found) begin
                    found = 1'b1;
                    ff    = k;
                    if (stop_on_fail) begin
                        nvec  = k + 1;
                        fstim = k;
                        break;
                    end
                end
            end
        end
        cycles = nvec * (settle + 1);
    endtask

    task automatic set_start(input bit v);
        if (sel != 0) start2 = v;
        else          start4 = v;
    endtask

    // Launch one run on the selected instance and check everything it reports
    task automatic run(input int which, input logic [15:0] tt, input bit hold);
        logic [15:0] ref_tt;
        int n, settle, e_err, e_ff, e_stim, e_cyc, cyc, prev;
        bit mono;
        sel = which;
        if (which != 0) begin
            dut_tt2 = tt[3:0]; ref_tt = 16'h0006; n = 2; settle = 1;
        end else begin
            dut_tt4 = tt;      ref_tt = 16'h8000; n = 4; settle = 2;
        end
        predict(tt, ref_tt, n, settle, e_err, e_ff, e_stim, e_cyc);

        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        if (!hold) set_start(1'b0);
        check("busy_rise", v_busy, 1);
        check("done_clr", v_done, 0);
        check("err_clr", v_err, 0);
        check("fs_clr", v_fs, 0);
        check("stim_first", v_stim, 0);

        cyc  = 0;
        mono = 1'b1;
        prev = 0;
        while (!v_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (v_stim < prev || v_stim > prev + 1) mono = 1'b0;
            prev = v_stim;
        end
        set_start(1'b0);
        check("run_cycles", cyc, e_cyc);
        check("busy_fall", v_busy, 0);
        check("stim_mono", mono, 1);
        check("err_count", v_err, e_err);
        check("first_fail", v_ff, e_ff);
        check("fail_seen", v_fs, (e_err != 0) ? 1 : 0);
        check("pass", v_pass, (e_err == 0) ? 1 : 0);
        check("stim_final", v_stim, e_stim);

        // Results hold in DONE without start
        repeat (3) @(negedge clk);
        check("done_hold", v_done, 1);
        check("err_hold", v_err, e_err);
    endtask

    initial begin
        int guard;
        #12;
        check("rst_stim4", stim4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_pass4", pass4, 0);
        check("rst_err4", err4, 0);
        check("rst_ff4", ff4, 0);
        check("rst_fs4", fs4, 0);
        check("rst_busy2", busy2, 0);
        check("rst_done2", done2, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed cases: AND, OR, OR with start held, XOR, XNOR
        run(0, 16'h8000, 1'b0);
        run(0, 16'hFFFE, 1'b0);
        run(0, 16'hFFFE, 1'b1);
        run(1, 16'h0006, 1'b0);
        run(1, 16'h0009, 1'b0);

        // Randomized truth tables, restarting from DONE each time
        for (int i = 0; i < 6; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if (i == 0) r = 16'h8000 ^ (16'h1 << $urandom_range(15, 0));
            run(0, r, 1'($urandom_range(1, 0)));
        end
        for (int i = 0; i < 4; i++) begin
            run(1, 16'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
        end

        // Reset mid-run at stim 6
        sel = 0;
        dut_tt4 = 16'hFFFE;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        guard = 0;
        while (stim4 != 4'h6 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reach_stim6", stim4, 6);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy4, 0);
        check("abort_stim", stim4, 0);
        check("abort_err", err4, 0);
        check("abort_done", done4, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_done_after_abort", done4, 0);
        check("idle_after_abort", busy4, 0);
        run(0, 16'h8000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound in case a run never finishes
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_exhaustive_tester

`default_nettype wire
